anim_sequencer: RTL and testbench

ANIM_SEQUENCER -- requirements
Module: anim_sequencer

---
 rtl/anim_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_anim_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/anim_sequencer.sv
// Sprite animation sequencer: walks channels through DRAW/WAIT/ERASE/UPDATE per frame, chaining between channels.
// Latency: go -> first DRAW request one cycle later; each op advances one cycle after op_ack.
// Backpressure: DRAW/ERASE/UPDATE stall until op_ack; abort and reset cancel at any point.
module anim_sequencer #(
  parameter int NCH = 3,
  parameter int FW  = 4,
  parameter int WW  = 24,
  parameter int CW  = ($clog2(NCH) < 1) ? 1 : $clog2(NCH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic [CW-1:0]     start_ch,
  input  logic [NCH*FW-1:0] frames_i,
  input  logic [NCH-1:0]    chain_en,
  input  logic [NCH-1:0]    preempt_en,
  input  logic              preempt,
  input  logic [WW-1:0]     wait_cycles,
  input  logic              abort,
  input  logic              op_ack,
  output logic              op_req,
  output logic [1:0]        op_code,
  output logic [CW-1:0]     cur_ch,
  output logic [FW-1:0]     frame_idx,
  output logic              busy,
  output logic              done,
  output logic              preempted
);

  localparam int CWP1 = CW + 1;
  // Channel count at CW+1 bits so start_ch can be range-checked without overflow.
  localparam logic [CW:0]   NCH_V   = CWP1'(NCH);
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  localparam logic [1:0] OP_DRAW   = 2'b00;
  localparam logic [1:0] OP_ERASE  = 2'b01;
  localparam logic [1:0] OP_UPDATE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAW   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ERASE  = 3'd3,
    ST_UPDATE = 3'd4,
    ST_NEXT   = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cur_ch_q;
  logic [FW-1:0] frame_idx_q;
  logic [WW-1:0] wait_cnt_q;
  logic          pflag_q;
  logic          preempted_q;

  // Frame count of an arbitrary channel, selected by compare so non-power-of-two NCH never indexes out of range.
  function automatic logic [FW-1:0] frames_of(input logic [NCH*FW-1:0] v, input logic [CW-1:0] ch);
    logic [FW-1:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch == CW'(c)) r = v[c*FW +: FW];
    end
    return r;
  endfunction

  // Per-channel enable bit, selected the same way.
  function automatic logic bit_of(input logic [NCH-1:0] v, input logic [CW-1:0] ch);
    logic r;
    r = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (ch == CW'(c)) r = v[c];
    end
    return r;
  endfunction

  logic          start_ok;
  logic [CW-1:0] next_ch;
  logic [FW:0]   idx_plus1;
  logic [FW:0]   cur_frames_x;
  logic          last_frame;
  logic          chain_go;

  // Frame-completion compare is done one bit wider so frame_idx+1 cannot wrap into a false match.
  assign start_ok     = ({1'b0, start_ch} < NCH_V);
  assign next_ch      = cur_ch_q + {{(CW-1){1'b0}}, 1'b1};
  assign idx_plus1    = {1'b0, frame_idx_q} + {{FW{1'b0}}, 1'b1};
  assign cur_frames_x = {1'b0, frames_of(frames_i, cur_ch_q)};
  assign last_frame   = (idx_plus1 == cur_frames_x);
  // A preempted channel always hands over; otherwise only when its chain bit is set.
  assign chain_go     = (bit_of(chain_en, cur_ch_q) || pflag_q) && (cur_ch_q != LAST_CH);

  // Sequencer state machine: channel/frame bookkeeping, wait timer, preemption flag and pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_ch_q    <= '0;
      frame_idx_q <= '0;
      wait_cnt_q  <= '0;
      pflag_q     <= 1'b0;
      preempted_q <= 1'b0;
    end else begin
      preempted_q <= 1'b0;
      if (abort && (state_q != ST_IDLE)) begin
        // Cancel wins over everything else; position registers are left as they were.
        state_q <= ST_IDLE;
        pflag_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (go && start_ok) begin
              cur_ch_q    <= start_ch;
              frame_idx_q <= '0;
              // Entry evaluation: a zero-frame channel is already complete.
              state_q     <= (frames_of(frames_i, start_ch) != '0) ? ST_DRAW : ST_NEXT;
            end
          end
          ST_DRAW: begin
            if (op_ack) begin
              wait_cnt_q <= wait_cycles;
              state_q    <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (preempt && bit_of(preempt_en, cur_ch_q)) begin
              preempted_q <= 1'b1;
              pflag_q     <= 1'b1;
              state_q     <= ST_ERASE;
            end else if (wait_cnt_q == '0) begin
              state_q <= ST_ERASE;
            end else begin
              wait_cnt_q <= wait_cnt_q - {{(WW-1){1'b0}}, 1'b1};
            end
          end
          ST_ERASE: begin
            if (op_ack) begin
              state_q <= pflag_q ? ST_NEXT : ST_UPDATE;
            end
          end
          ST_UPDATE: begin
            if (op_ack) begin
              if (last_frame) begin
                state_q <= ST_NEXT;
              end else begin
                frame_idx_q <= idx_plus1[FW-1:0];
                state_q     <= ST_DRAW;
              end
            end
          end
          ST_NEXT: begin
            // The preempt flag is consumed here so a following zero-frame channel uses its own chain bit.
            pflag_q <= 1'b0;
            if (chain_go) begin
              cur_ch_q    <= next_ch;
              frame_idx_q <= '0;
              state_q     <= (frames_of(frames_i, next_ch) != '0) ? ST_DRAW : ST_NEXT;
            end else begin
              state_q <= ST_DONE;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Output decode straight from the state register: no path from op_ack to op_req.
  always_comb begin
    op_req  = 1'b0;
    op_code = OP_DRAW;
    case (state_q)
      ST_DRAW:   begin op_req = 1'b1; op_code = OP_DRAW;   end
      ST_ERASE:  begin op_req = 1'b1; op_code = OP_ERASE;  end
      ST_UPDATE: begin op_req = 1'b1; op_code = OP_UPDATE; end
      default:   begin op_req = 1'b0; op_code = OP_DRAW;   end
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign preempted = preempted_q;
  assign cur_ch    = cur_ch_q;
  assign frame_idx = frame_idx_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Self-checking bench for anim_sequencer: transaction-level reference model of frames/channels.
// Latency: n/a (bench).
// Backpressure: bench acks ops after random 0..2 cycle delays and injects ignored acks/preempts.
module tb_anim_sequencer;
  localparam int NCH = 3;
  localparam int FW  = 4;
  localparam int WW  = 24;
  localparam int CW  = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              go = 1'b0;
  logic [CW-1:0]     start_ch = '0;
  logic [NCH*FW-1:0] frames_i = '0;
  logic [NCH-1:0]    chain_en = '0;
  logic [NCH-1:0]    preempt_en = '0;
  logic              preempt = 1'b0;
  logic [WW-1:0]     wait_cycles = '0;
  logic              abort = 1'b0;
  logic              op_ack = 1'b0;
  logic              op_req;
  logic [1:0]        op_code;
  logic [CW-1:0]     cur_ch;
  logic [FW-1:0]     frame_idx;
  logic              busy;
  logic              done;
  logic              preempted;

  anim_sequencer #(.NCH(NCH), .FW(FW), .WW(WW), .CW(CW)) dut (
    .clock(clock), .reset(reset), .go(go), .start_ch(start_ch), .frames_i(frames_i),
    .chain_en(chain_en), .preempt_en(preempt_en), .preempt(preempt), .wait_cycles(wait_cycles),
    .abort(abort), .op_ack(op_ack), .op_req(op_req), .op_code(op_code), .cur_ch(cur_ch),
    .frame_idx(frame_idx), .busy(busy), .done(done), .preempted(preempted)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Op record: code*256 + channel*16 + frame index.
  function automatic int mk(input int code, input int ch, input int idx);
    return code * 256 + ch * 16 + idx;
  endfunction

  int exp_ops[$];
  int obs_ops[$];
  int exp_gaps[$];
  int obs_gaps[$];

  task automatic run_seq(input string name, input int st, input int f0, input int f1, input int f2,
                         input logic [2:0] ch_en, input logic [2:0] pen, input int wt,
                         input bit pl_on, input int pl_ch, input int pl_f, input int pl_j);
    int fr[NCH];
    int ch, last_idx, exp_pre, pre_seen, budget, ack_d, gap, widx, nmin;
    bit pre, fin, new_op, in_gap, armed, busy_drop, got_done;
    fr[0] = f0; fr[1] = f1; fr[2] = f2;
    exp_ops.delete(); obs_ops.delete(); exp_gaps.delete(); obs_gaps.delete();

    // Reference model: list every op the sequence must issue, frame by frame, channel by channel.
    ch = st; exp_pre = 0; fin = 0; last_idx = 0;
    while (!fin) begin
      pre = 0; last_idx = 0;
      for (int f = 0; f < fr[ch]; f++) begin
        last_idx = f;
        exp_ops.push_back(mk(0, ch, f));
        if (pl_on && pl_ch == ch && pl_f == f && pen[ch]) begin
          exp_gaps.push_back(pl_j + 1);
          exp_ops.push_back(mk(1, ch, f));
          pre = 1; exp_pre++;
          break;
        end
        exp_gaps.push_back(wt + 1);
        exp_ops.push_back(mk(1, ch, f));
        exp_ops.push_back(mk(2, ch, f));
      end
      if ((ch_en[ch] || pre) && ch < NCH - 1) ch++;
      else fin = 1;
    end

    frames_i = {4'(f2), 4'(f1), 4'(f0)};
    chain_en = ch_en; preempt_en = pen; wait_cycles = WW'(wt);
    @(negedge clock); go = 1'b1; start_ch = CW'(st);
    @(negedge clock); go = 1'b0;

    pre_seen = 0; budget = 0; ack_d = 0; gap = 0; widx = 0;
    new_op = 1; in_gap = 0; armed = 0; busy_drop = 0; got_done = 0;
    while (!got_done && budget < 4000) begin
      op_ack = 1'b0; preempt = 1'b0;
      if (busy !== 1'b1) busy_drop = 1;
      if (preempted === 1'b1) pre_seen++;
      if (done === 1'b1) got_done = 1;
      else begin
        if (in_gap) begin
          if (op_req) begin obs_gaps.push_back(gap); in_gap = 0; end
          else gap++;
        end
        if (armed) begin
          if (widx == pl_j) begin preempt = 1'b1; armed = 0; end
          widx++;
        end
        if (op_req) begin
          if (new_op) begin ack_d = $urandom_range(0, 2); new_op = 0; end
          if (ack_d == 0) begin
            op_ack = 1'b1; new_op = 1;
            obs_ops.push_back(mk(op_code, cur_ch, frame_idx));
            if (op_code == 2'b00) begin
              in_gap = 1; gap = 0;
              if (pl_on && cur_ch == CW'(pl_ch) && frame_idx == FW'(pl_f)) begin armed = 1; widx = 0; end
            end
          end else ack_d--;
          if ($urandom_range(0, 3) == 0) preempt = 1'b1;
        end else if ($urandom_range(0, 3) == 0) op_ack = 1'b1;
        @(negedge clock); budget++;
      end
    end
    op_ack = 1'b0; preempt = 1'b0;

    check({name, ":done_seen"}, 32'(got_done), 1);
    if (!got_done) begin
      abort = 1'b1; @(negedge clock); abort = 1'b0;
    end
    check({name, ":busy_during"}, 32'(busy_drop), 0);
    check({name, ":preempted_cnt"}, pre_seen, exp_pre);
    check({name, ":n_ops"}, obs_ops.size(), exp_ops.size());
    nmin = (obs_ops.size() < exp_ops.size()) ? obs_ops.size() : exp_ops.size();
    for (int i = 0; i < nmin; i++) check($sformatf("%s:op%0d", name, i), obs_ops[i], exp_ops[i]);
    check({name, ":n_waits"}, obs_gaps.size(), exp_gaps.size());
    nmin = (obs_gaps.size() < exp_gaps.size()) ? obs_gaps.size() : exp_gaps.size();
    for (int i = 0; i < nmin; i++) check($sformatf("%s:wait%0d", name, i), obs_gaps[i], exp_gaps[i]);
    check({name, ":final_ch"}, cur_ch, ch);
    check({name, ":final_idx"}, frame_idx, last_idx);
    @(negedge clock);
    check({name, ":done_pulse_end"}, done, 0);
    check({name, ":idle_after"}, busy, 0);
    check({name, ":ch_hold"}, cur_ch, ch);
    check({name, ":idx_hold"}, frame_idx, last_idx);
  endtask

  // Acks every op immediately until an op with the given code is requested (or the budget runs out).
  task automatic ack_until(input logic [1:0] code, output bit found);
    found = 0;
    for (int n = 0; n < 500 && !found; n++) begin
      op_ack = 1'b0;
      if (op_req && op_code == code) found = 1;
      else begin
        if (op_req) op_ack = 1'b1;
        @(negedge clock);
      end
    end
    op_ack = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int wt, pj;

    // Reset is asynchronous: outputs settle before any clock edge.
    #3;
    check("rst_op_req", op_req, 0);
    check("rst_op_code", op_code, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cur_ch", cur_ch, 0);
    check("rst_frame_idx", frame_idx, 0);
    check("rst_preempted", preempted, 0);
    @(negedge clock); reset = 1'b0;
    @(negedge clock);

    run_seq("single_ch0", 0, 2, 3, 5, 3'b000, 3'b000, 2, 0, 0, 0, 0);
    run_seq("chain_all", 0, 2, 3, 5, 3'b011, 3'b000, 2, 0, 0, 0, 0);
    run_seq("preempt_ch0", 0, 2, 3, 5, 3'b000, 3'b001, 2, 1, 0, 0, 1);
    run_seq("skip_zero_ch1", 0, 2, 0, 5, 3'b011, 3'b000, 1, 0, 0, 0, 0);
    run_seq("zero_start", 2, 1, 1, 0, 3'b111, 3'b000, 0, 0, 0, 0, 0);
    run_seq("preempt_last", 2, 1, 1, 3, 3'b000, 3'b100, 3, 1, 2, 1, 3);
    run_seq("preempt_masked", 1, 1, 2, 1, 3'b000, 3'b101, 1, 1, 1, 0, 0);

    for (int i = 0; i < 20; i++) begin
      wt = $urandom_range(0, 3);
      pj = $urandom_range(0, wt);
      run_seq($sformatf("rnd%0d", i), $urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), wt,
              1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3), pj);
    end

    // Abort coinciding with op_ack in UPDATE: back to IDLE, no done pulse.
    frames_i = {4'd5, 4'd3, 4'd2}; chain_en = 3'b000; preempt_en = 3'b000; wait_cycles = '0;
    @(negedge clock); go = 1'b1; start_ch = 2'd0;
    @(negedge clock); go = 1'b0;
    ack_until(2'b10, found);
    check("abort_reach_update", 32'(found), 1);
    abort = 1'b1; op_ack = 1'b1;
    @(negedge clock); abort = 1'b0; op_ack = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_op_req", op_req, 0);
    check("abort_no_done", done, 0);
    @(negedge clock);
    check("abort_no_done_late", done, 0);
    check("abort_stays_idle", busy, 0);

    // go with an out-of-range channel is ignored.
    go = 1'b1; start_ch = 2'd3;
    @(negedge clock); go = 1'b0;
    check("bad_start_busy", busy, 0);
    @(negedge clock);
    check("bad_start_busy_late", busy, 0);
    check("bad_start_op_req", op_req, 0);

    // Reset mid-WAIT between clock edges.
    frames_i = {4'd3, 4'd3, 4'd3}; wait_cycles = WW'(20);
    go = 1'b1; start_ch = 2'd2;
    @(negedge clock); go = 1'b0;
    ack_until(2'b00, found);
    check("rstw_reach_draw", 32'(found), 1);
    op_ack = 1'b1;
    @(negedge clock); op_ack = 1'b0;
    @(negedge clock);
    check("rstw_in_wait_busy", busy, 1);
    check("rstw_in_wait_ch", cur_ch, 2);
    #2 reset = 1'b1;
    #1;
    check("rstw_op_req", op_req, 0);
    check("rstw_op_code", op_code, 0);
    check("rstw_busy", busy, 0);
    check("rstw_done", done, 0);
    check("rstw_cur_ch", cur_ch, 0);
    check("rstw_frame_idx", frame_idx, 0);
    check("rstw_preempted", preempted, 0);
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    check("rstw_idle_after", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
